// File: rtl/car_park_pkg.sv
// ---------------------------------------------------------------------------
// car_park_pkg
// Shared definitions for the car park controller:
//   - gate_state_t : entry barrier FSM state encoding
//   - DEFAULT_CAPACITY / DEFAULT_GATE_TIMEOUT : production parameter values
// ---------------------------------------------------------------------------
package car_park_pkg;

    typedef enum logic [1:0] {
        GATE_IDLE  = 2'b00,
        GATE_OPEN  = 2'b01,
        GATE_REARM = 2'b10
    } gate_state_t;

    localparam int DEFAULT_CAPACITY     = 99;
    localparam int DEFAULT_GATE_TIMEOUT = 5000000;

endpackage

// File: rtl/occupancy_counter.sv
// ---------------------------------------------------------------------------
// occupancy_counter
// Saturating occupancy counter driven by one-cycle enter/exit pulses.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   enter, exit     : one-cycle pulses from the occupancy sensor FSM
//   err_clr         : one-cycle pulse clearing the sticky error
//   count           : current occupancy (registered)
//   full, empty     : count == CAPACITY / count == 0 (registered, same
//                     cycle as count)
//   err             : sticky overflow/underflow attempt flag
// ---------------------------------------------------------------------------
module occupancy_counter
    import car_park_pkg::*;
#(
    parameter int CAPACITY = DEFAULT_CAPACITY,
    parameter int CW       = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enter,
    input  logic          exit,
    input  logic          err_clr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          err
);

    localparam logic [CW-1:0] CAP_C  = CW'(CAPACITY);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          full_r;
    logic          empty_r;
    logic          err_r;
    logic          err_set_s;

    // Next occupancy and error detection from the enter/exit pulse pair.
    always_comb begin
        count_next_s = count_r;
        err_set_s    = 1'b0;
        case ({enter, exit})
            2'b10: begin
                if (count_r < CAP_C) begin
                    count_next_s = count_r + ONE_C;
                end else begin
                    err_set_s = 1'b1;
                end
            end
            2'b01: begin
                if (count_r != ZERO_C) begin
                    count_next_s = count_r - ONE_C;
                end else begin
                    err_set_s = 1'b1;
                end
            end
            default: begin
                // Simultaneous enter/exit cancel out; no pulse holds.
                count_next_s = count_r;
                err_set_s    = 1'b0;
            end
        endcase
    end

    // Count, flag and sticky error registers. full/empty are registered from
    // the next count so they line up with count without extra latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= ZERO_C;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            full_r  <= (count_next_s == CAP_C);
            empty_r <= (count_next_s == ZERO_C);
            // A new error in the same cycle as err_clr keeps err set.
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;
    assign err   = err_r;

endmodule

// File: rtl/car_park_controller.sv
// ---------------------------------------------------------------------------
// car_park_controller
// Occupancy tracking plus entry barrier sequencing.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   enter, exit     : one-cycle pulses from the sensor FSM (car passed)
//   req             : driver request level at the entry barrier
//   err_clr         : one-cycle pulse clearing err
//   gate_open       : barrier open command (registered Moore output)
//   count           : current occupancy
//   full, empty     : occupancy at CAPACITY / zero
//   err             : sticky entry-while-full / exit-while-empty flag
// ---------------------------------------------------------------------------
module car_park_controller
    import car_park_pkg::*;
#(
    parameter int CAPACITY     = DEFAULT_CAPACITY,
    parameter int CW           = 7,
    parameter int GATE_TIMEOUT = DEFAULT_GATE_TIMEOUT,
    parameter int TW           = 23
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enter,
    input  logic          exit,
    input  logic          req,
    input  logic          err_clr,
    output logic          gate_open,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          err
);

    localparam logic [TW-1:0] TIMER_LAST_C = TW'(GATE_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE_C  = TW'(1);
    localparam logic [TW-1:0] TIMER_ZERO_C = {TW{1'b0}};

    gate_state_t   state_r;
    gate_state_t   state_next_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_next_s;
    logic          gate_open_r;
    logic          full_s;

    occupancy_counter #(
        .CAPACITY (CAPACITY),
        .CW       (CW)
    ) u_occupancy_counter (
        .clk     (clk),
        .reset   (reset),
        .enter   (enter),
        .exit    (exit),
        .err_clr (err_clr),
        .count   (count),
        .full    (full_s),
        .empty   (empty),
        .err     (err)
    );

    // Gate next-state and timer logic. Uses the registered full flag so a
    // request is judged against the occupancy visible this cycle.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        case (state_r)
            GATE_IDLE: begin
                if (req && !full_s) begin
                    state_next_s = GATE_OPEN;
                    timer_next_s = TIMER_ZERO_C;
                end else begin
                    state_next_s = GATE_IDLE;
                end
            end
            GATE_OPEN: begin
                // Car passed or driver gave up; either way close and rearm.
                if (enter || (timer_r == TIMER_LAST_C)) begin
                    state_next_s = GATE_REARM;
                    timer_next_s = TIMER_ZERO_C;
                end else begin
                    timer_next_s = timer_r + TIMER_ONE_C;
                end
            end
            GATE_REARM: begin
                // A held button must be released before another opening.
                if (!req) begin
                    state_next_s = GATE_IDLE;
                end else begin
                    state_next_s = GATE_REARM;
                end
            end
            default: begin
                state_next_s = GATE_IDLE;
                timer_next_s = TIMER_ZERO_C;
            end
        endcase
    end

    // Gate state, timer and registered barrier command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= GATE_IDLE;
            timer_r     <= TIMER_ZERO_C;
            gate_open_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            timer_r     <= timer_next_s;
            gate_open_r <= (state_next_s == GATE_OPEN);
        end
    end

    assign gate_open = gate_open_r;
    assign full      = full_s;

endmodule

// File: tb/tb_car_park_controller.sv
// ---------------------------------------------------------------------------
// tb_car_park_controller
// Directed scenarios followed by random traffic, every cycle compared with a
// behavioural model of the car park (occupancy integer, barrier up/down,
// "button released since last close" flag, open age in cycles).
// ---------------------------------------------------------------------------
module tb_car_park_controller;

    localparam int CAP = 5;
    localparam int CW  = 3;
    localparam int TO  = 8;
    localparam int TW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enter;
    logic          exit;
    logic          req;
    logic          err_clr;
    logic          gate_open;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          err;

    car_park_controller #(
        .CAPACITY     (CAP),
        .CW           (CW),
        .GATE_TIMEOUT (TO),
        .TW           (TW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enter     (enter),
        .exit      (exit),
        .req       (req),
        .err_clr   (err_clr),
        .gate_open (gate_open),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the lot.
    int occ_m;
    bit err_m;
    bit up_m;
    bit released_m;
    int age_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the currently applied inputs.
    function automatic void model_step();
        bit was_full;
        bit new_err;
        if (reset) begin
            occ_m      = 0;
            err_m      = 1'b0;
            up_m       = 1'b0;
            released_m = 1'b1;
            age_m      = 0;
        end else begin
            was_full = (occ_m == CAP);
            new_err  = 1'b0;
            if (enter && !exit) begin
                if (occ_m < CAP) occ_m = occ_m + 1;
                else new_err = 1'b1;
            end else if (exit && !enter) begin
                if (occ_m > 0) occ_m = occ_m - 1;
                else new_err = 1'b1;
            end
            if (new_err) err_m = 1'b1;
            else if (err_clr) err_m = 1'b0;

            if (up_m) begin
                if (enter || age_m == TO - 1) begin
                    up_m       = 1'b0;
                    released_m = 1'b0;
                end else begin
                    age_m = age_m + 1;
                end
            end else if (!released_m) begin
                if (!req) released_m = 1'b1;
            end else if (req && !was_full) begin
                up_m  = 1'b1;
                age_m = 0;
            end
        end
    endfunction

    // One clock: update model, let DUT clock, compare all outputs, clear pulses.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(occ_m));
        check("full", 32'(full), 32'(occ_m == CAP));
        check("empty", 32'(empty), 32'(occ_m == 0));
        check("err", 32'(err), 32'(err_m));
        check("gate_open", 32'(gate_open), 32'(up_m));
        reset   = 1'b0;
        enter   = 1'b0;
        exit    = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        enter   = 1'b0;
        exit    = 1'b0;
        req     = 1'b0;
        err_clr = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_gate", 32'(gate_open), 32'd0);

        // Three entries and one exit, spaced apart.
        for (int i = 0; i < 3; i++) begin
            enter = 1'b1; cycle(); cycle();
        end
        exit = 1'b1; cycle(); cycle();
        check("t1_count", 32'(count), 32'd2);
        check("t1_empty", 32'(empty), 32'd0);
        check("t1_err", 32'(err), 32'd0);

        // Fill the lot; requests refused; overflow sets err; err_clr clears.
        for (int i = 0; i < 3; i++) begin
            enter = 1'b1; cycle();
        end
        check("t2_full", 32'(full), 32'd1);
        req = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("t2_refused", 32'(gate_open), 32'd0);
        enter = 1'b1; cycle();
        check("t2_cnt_sat", 32'(count), 32'(CAP));
        check("t2_err_set", 32'(err), 32'd1);
        err_clr = 1'b1; cycle();
        check("t2_err_clr", 32'(err), 32'd0);
        req = 1'b0; cycle();

        // Drain, underflow, then simultaneous enter/exit.
        for (int i = 0; i < CAP; i++) begin
            exit = 1'b1; cycle();
        end
        exit = 1'b1; cycle();
        check("t3_cnt_zero", 32'(count), 32'd0);
        check("t3_err_set", 32'(err), 32'd1);
        err_clr = 1'b1; cycle();
        enter = 1'b1; cycle();
        enter = 1'b1; exit = 1'b1; cycle();
        check("t3_both_cnt", 32'(count), 32'd1);
        check("t3_both_err", 32'(err), 32'd0);

        // Timeout with a one-cycle request.
        req = 1'b1; cycle();
        check("t4_opened", 32'(gate_open), 32'd1);
        req = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            cycle();
            check("t4_still_open", 32'(gate_open), 32'd1);
        end
        cycle();
        check("t4_timeout", 32'(gate_open), 32'd0);
        cycle(); cycle();

        // Timeout with request held: stays closed until released.
        req = 1'b1;
        for (int i = 0; i < TO; i++) cycle();
        cycle();
        check("t4_held_close", 32'(gate_open), 32'd0);
        for (int i = 0; i < 4; i++) cycle();
        check("t4_rearm", 32'(gate_open), 32'd0);
        req = 1'b0; cycle();
        req = 1'b1; cycle();
        check("t4_reopen", 32'(gate_open), 32'd1);

        // Car passes while open, request kept high.
        cycle();
        enter = 1'b1; cycle();
        check("t5_closed", 32'(gate_open), 32'd0);
        check("t5_count", 32'(count), 32'd2);
        for (int i = 0; i < 3; i++) cycle();
        check("t5_no_reopen", 32'(gate_open), 32'd0);
        req = 1'b0; cycle();

        // Reset while open.
        req = 1'b1; cycle();
        check("t6_open", 32'(gate_open), 32'd1);
        reset = 1'b1; cycle();
        check("t6_gate", 32'(gate_open), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        cycle();
        check("t6_idle_reopen", 32'(gate_open), 32'd1);
        req = 1'b0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 6) == 0) req = ~req;
            enter   = ($urandom_range(0, 3) == 0);
            exit    = ($urandom_range(0, 4) == 0);
            err_clr = ($urandom_range(0, 19) == 0);
            reset   = ($urandom_range(0, 149) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/car_park_controller.md
Name: car_park_controller

Overview:
Occupancy and entry-gate controller for the parking lot. It consumes the one-cycle `enter`/`exit` pulses produced by the car park occupancy sensor FSM and keeps a saturating occupancy count with full, empty and error flags. It also sequences the entry barrier from a driver request: open on demand, close after passage or timeout, refuse to open when the lot is full. It sits between the sensor FSM and the gate actuator and display logic.

Parameters:
CAPACITY, 99, number of spaces; the count never exceeds this value.
CW, 7, width of `count`; must satisfy 2^CW > CAPACITY.
GATE_TIMEOUT, 5000000, cycles the barrier stays open waiting for a car before closing.
TW, 23, width of the gate timer; must satisfy 2^TW >= GATE_TIMEOUT.

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high
enter  in  1  one-cycle pulse: a car completed entry (from sensor FSM)
exit  in  1  one-cycle pulse: a car completed exit (from sensor FSM)
req  in  1  level; driver request at the entry barrier (button or ticket)
err_clr  in  1  one-cycle pulse; clears `err`
gate_open  out  1  barrier open command, registered Moore output
count  out  CW  current occupancy, registered
full  out  1  count == CAPACITY
empty  out  1  count == 0
err  out  1  sticky error: entry seen while full, or exit seen while empty

Behaviour:
- All state updates on the rising edge of `clk`. Reset is synchronous, active-high, and dominates every other input.
- Reset values: `count`=0, `empty`=1, `full`=0, `err`=0, `gate_open`=0, gate FSM = IDLE, timer=0.
- `full` and `empty` are decoded from the `count` register. They have no extra latency relative to `count`.
- Counter update, evaluated each cycle:
  - `enter`&`exit` together: `count` unchanged, no error.
  - `enter` only: if `count`<CAPACITY then `count`+1; else `count` holds and `err` is set.
  - `exit` only: if `count`>0 then `count`-1; else `count` holds and `err` is set.
  - Neither: hold.
- Latency: a pulse sampled in cycle N is reflected in `count`/`full`/`empty` in cycle N+1.
- `enter` is counted in every gate state, so tailgating still updates occupancy.
- `err` is sticky until `err_clr`. If `err_clr` and a new error condition occur in the same cycle, `err` stays 1 (set wins).
- Gate FSM has three states:
  - IDLE, `gate_open`=0:
    - `req` & ~`full` → OPEN, timer cleared.
    - `req` & `full` → stay IDLE (entry refused).
  - OPEN, `gate_open`=1: timer increments each cycle.
    - `enter` → REARM.
    - timer == GATE_TIMEOUT-1 → REARM (driver gave up).
    - If both happen in the same cycle, go to REARM; the `enter` is still counted.
  - REARM, `gate_open`=0: wait for ~`req` → IDLE. This stops a held button from re-opening the barrier.
- Gate latency: `req` sampled in cycle N (in IDLE) gives `gate_open`=1 in cycle N+1. An `enter` in cycle M (in OPEN) gives `gate_open`=0 in cycle M+1.
- Use the registered `full` when sampling `req`. If the lot becomes full while OPEN, the barrier stays open; that car was already granted entry.
- `exit` has no effect on the gate FSM.
- Reset mid-operation, including while OPEN, closes the barrier on the next edge and clears the count.
- Illegal FSM encodings go to IDLE.

Decomposition:
- Shared package `car_park_pkg`:
  - gate state localparams (IDLE=2'b00, OPEN=2'b01, REARM=2'b10);
  - default CAPACITY and GATE_TIMEOUT constants.
- One sub-module: `occupancy_counter`.
  - Parameters CAPACITY, CW.
  - Ports clk, reset, enter, exit, err_clr → count, full, empty, err.
- The gate FSM and its timer stay in the top level.

Test Plan:
1. Reset, then 3 `enter` pulses and 1 `exit` pulse, spaced apart → `count`=2, `empty`=0, `full`=0, `err`=0.
2. CAPACITY=3: 3 entries, then `req`=1 → `full`=1 and `gate_open` stays 0. A 4th `enter` → `count`=3, `err`=1. `err_clr` → `err`=0.
3. From empty, `exit` pulse → `count`=0, `err`=1. Then `enter`&`exit` in the same cycle at `count`=1 → `count`=1, no new error.
4. GATE_TIMEOUT=8: `req` held 1 cycle in IDLE → `gate_open`=1 next cycle. No `enter` → `gate_open`=0 exactly 8 cycles after opening. `req` kept high → stays closed (REARM) until `req`=0, then reopens on the next `req`.
5. Gate OPEN, `enter` pulse → `gate_open`=0 and `count`+1 on the next cycle. With `req` held high throughout, the gate does not reopen until `req` drops.
6. Gate OPEN with `count`=5, assert `reset` for 1 cycle → next cycle `gate_open`=0, `count`=0, `empty`=1, FSM in IDLE.
